// File: rtl/blinker_pkg.sv
// blinker_pkg: mode encodings and field widths shared by the blinker bank.
package blinker_pkg;

    localparam int BURST_W = 4;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

endpackage

// File: rtl/blinker_channel.sv
// blinker_channel: one channel's config, phase counter, blink edge detect and b_en register.
// BLINKER_BANK_BURST_EN adds the burst_left counter; otherwise BURST behaves as BLINK.
module blinker_channel
    import blinker_pkg::*;
#(
    parameter int C_BITS = 8,
    parameter int C_ON   = 2,
    parameter int C_OFF  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               wr,
    input  logic               blink,
    input  mode_t              cfg_mode,
    input  logic [C_BITS-1:0]  cfg_on,
    input  logic [C_BITS-1:0]  cfg_off,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               b_en
);

    localparam int PW = C_BITS + 1;

    mode_t             mode, mode_n;
    logic [C_BITS-1:0] on, on_n, off, off_n;
    logic [PW-1:0]     phase, phase_n, phase_inc, p;
    logic              blink_q, rise, on_phase, burst_ok, b_en_n;

    always_comb begin
        mode_n    = wr ? cfg_mode : mode;
        on_n      = wr ? cfg_on : on;
        off_n     = wr ? cfg_off : off;
        rise      = blink & ~blink_q;
        p         = PW'(on) + PW'(off);
        phase_inc = phase + 1'b1;
        phase_n   = (wr | rise) ? '0 : !tick ? phase : (phase_inc >= p) ? '0 : phase_inc;
        on_phase  = phase_n < PW'(on_n);
        b_en_n    = mode_n == MODE_OFF ? 1'b0 :
                    mode_n == MODE_ON  ? 1'b1 :
                    ~blink | (on_phase & (mode_n != MODE_BURST | burst_ok));
    end

`ifdef BLINKER_BANK_BURST_EN
    logic [BURST_W-1:0] burst, burst_n, burst_left, burst_left_n;
    logic               wrap;

    // A write alone leaves the burst exhausted until the next blink edge reloads it.
    always_comb begin
        wrap         = tick & ~wr & ~rise & (p != '0) & (phase_inc >= p);
        burst_n      = wr ? cfg_burst : burst;
        burst_left_n = wr   ? (rise ? cfg_burst : '0) :
                       rise ? burst :
                       (wrap && burst_left != '0) ? burst_left - 1'b1 : burst_left;
        burst_ok     = burst_left_n != '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst      <= '0;
            burst_left <= '0;
        end else begin
            burst      <= burst_n;
            burst_left <= burst_left_n;
        end
    end
`else
    logic unused_burst;
    assign burst_ok     = 1'b1;
    assign unused_burst = ^cfg_burst;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode    <= MODE_BLINK;
            on      <= C_BITS'(C_ON);
            off     <= C_BITS'(C_OFF);
            phase   <= '0;
            blink_q <= 1'b0;
            b_en    <= 1'b1;
        end else begin
            mode    <= mode_n;
            on      <= on_n;
            off     <= off_n;
            phase   <= phase_n;
            blink_q <= blink;
            b_en    <= b_en_n;
        end
    end

endmodule

// File: rtl/blinker_bank.sv
// blinker_bank: N_CH configurable blinkers sharing one tick prescaler.
// BLINKER_BANK_BURST_EN enables BURST mode and the per-channel burst counters.
module blinker_bank
    import blinker_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int C_BITS   = 8,
    parameter  int C_ON     = 2,
    parameter  int C_OFF    = 3,
    parameter  int PRESCALE = 1,
    localparam int CH_W     = N_CH > 1 ? $clog2(N_CH) : 1,
    localparam int PS_W     = PRESCALE > 1 ? $clog2(PRESCALE) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_CH-1:0]    blink,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [C_BITS-1:0]  cfg_on,
    input  logic [C_BITS-1:0]  cfg_off,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic [N_CH-1:0]    b_en
);

    logic [PS_W-1:0] ps;
    logic            tick, cfg_ok;

    assign tick   = ps == PS_W'(PRESCALE - 1);
    assign cfg_ok = cfg_we && (32'(cfg_ch) < N_CH);

    always_ff @(posedge clk) begin
        if (!reset_n) ps <= '0;
        else          ps <= tick ? '0 : ps + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        blinker_channel #(
            .C_BITS (C_BITS),
            .C_ON   (C_ON),
            .C_OFF  (C_OFF)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .wr        (cfg_ok && cfg_ch == CH_W'(i)),
            .blink     (blink[i]),
            .cfg_mode  (mode_t'(cfg_mode)),
            .cfg_on    (cfg_on),
            .cfg_off   (cfg_off),
            .cfg_burst (cfg_burst),
            .b_en      (b_en[i])
        );
    end

endmodule

// File: doc/blinker_bank.md
# blinker_bank

Multi-channel, runtime-configurable successor to the single fixed-period blinker counter. It drives N_CH independent blink-enable outputs for the display/indicator path. Each channel has its own on/off period, mode and optional burst count, all written through a simple configuration port. A shared prescaler sets the tick rate, so periods are measured in ticks rather than raw clocks.

## Interface
- N_CH, 4: number of channels (1–16)
- C_BITS, 8: width of the on/off period fields, in ticks
- C_ON, 2: reset value of every channel's on-period
- C_OFF, 3: reset value of every channel's off-period
- PRESCALE, 1: clocks per tick (≥1); 1 means tick every clock
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- blink  in  N_CH  per-channel blink request (level)
- cfg_we  in  1  config write strobe, single cycle
- cfg_ch  in  max(1,$clog2(N_CH))  target channel
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
- cfg_on  in  C_BITS  on-period in ticks
- cfg_off  in  C_BITS  off-period in ticks
- cfg_burst  in  4  burst pulse count (BURST mode)
- b_en  out  N_CH  registered blink-enable per channel

## Operation
- Prescaler: counts 0..PRESCALE-1; `tick` is asserted in the cycle it equals PRESCALE-1, then it wraps to 0. It is shared by all channels.
- Per channel:
  - State: phase counter, C_BITS+1 wide.
  - Period P = on + off, computed at C_BITS+1 bits with no overflow.
  - On each tick, phase advances; phase == P-1 wraps to 0. This gives an exact period of on+off ticks.
- on_phase = (phase < on).
  - on=0: never on.
  - off=0: always on.
  - P=0: phase is held at 0 and on_phase=0.
- Rising edge of blink[i] (blink vs. its registered copy) clears phase to 0, so every blink starts at the beginning of its on-phase.
- Output function, registered:
  - OFF → 0.
  - ON → 1.
  - BLINK → ~blink | on_phase.
  - BURST → ~blink | (on_phase & burst_left≠0).
- BURST mode:
  - A blink rising edge loads burst_left = cfg_burst.
  - Each phase wrap while burst_left≠0 decrements it.
  - After the last wrap, output stays 0 until blink falls.
  - cfg_burst=0 gives 0 for the whole time blink is high.
- Config write: when cfg_we=1 and cfg_ch<N_CH, the channel's mode, on, off and burst are loaded, and phase and burst_left are cleared. A write with cfg_ch≥N_CH is ignored.
- A config write and a blink rising edge on the same channel in the same cycle resolve to the write. Phase is cleared either way; burst_left is loaded from the new cfg_burst.
- A tick coinciding with a phase clear (write or blink edge) resolves to the clear: phase=0, no advance.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - prescaler=0, all phases=0, burst_left=0, blink registers=0;
  - every channel to mode BLINK, on=C_ON, off=C_OFF, burst=0;
  - b_en = all ones.
- Reset during operation behaves the same, taking effect at the next edge and overriding any write in that cycle.
- b_en is computed from the state being loaded and the blink value sampled at the same edge. Latency is one clock from a blink, config or phase change to b_en.
- A config write at edge t takes full effect from edge t: b_en after t reflects the new mode with phase=0.
- Phase changes only on tick edges. With PRESCALE=1, a BLINK channel with on=2, off=3 produces a b_en pattern of 1,1,0,0,0 repeating.

## Configuration
- BLINKER_BANK_BURST_EN:
  - Defined: BURST mode, the burst_left counters and cfg_burst are implemented.
  - Undefined: mode 11 behaves exactly as BLINK, cfg_burst is ignored and no burst_left registers exist.

## Structure
- Package blinker_pkg holds:
  - mode encodings MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST;
  - the 2-bit mode typedef;
  - the burst field width, 4.
- Sub-module blinker_channel is instantiated N_CH times by a generate loop. It holds one channel's config registers, phase counter, blink edge detect, burst_left and b_en register.
- The prescaler and config address decode stay in blinker_bank.

## Test plan
- Reset, blink=0 → b_en all ones. Then blink[0]=1 with PRESCALE=1, C_ON=2, C_OFF=3 → b_en[0] = 1,1,0,0,0 repeating, period 5.
- PRESCALE=4, write ch1 on=1 off=1 BLINK, hold blink[1]=1 → b_en[1] is 1 for 4 clocks and 0 for 4 clocks.
- Write ch2 on=0 → b_en[2]=0 while blink high. Write on=3 off=0 → b_en[2] constantly 1. Write on=0 off=0 → constantly 0, phase stuck at 0.
- BURST (macro on): ch3 on=1 off=1 burst=3, raise blink[3] → exactly 3 pulses (1,0)×3, then 0. Drop and re-raise blink → 3 new pulses. Macro off → continuous blinking.
- Blink re-edge mid off-phase → b_en=1 on the next cycle. Write to cfg_ch=N_CH → no channel changes. A write coinciding with a blink edge → the new config applies with phase=0.
- Assert reset_n=0 mid-burst with a write in the same cycle → after the edge, all channels are back at reset values and b_en is all ones.
